// File: rtl/psa_pkg.sv
// Shared types and constants for the packed sub-word accumulator.
package psa_pkg;

  localparam int NIBBLES = 4;
  localparam int NIB_W   = 4;

  typedef logic signed [NIB_W-1:0] nib_t;
  typedef nib_t [NIBBLES-1:0]      psa_word_t;

  localparam nib_t NIB_MAX = 4'sh7;
  localparam nib_t NIB_MIN = 4'sh8;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } psa_acc_state_t;

endpackage

// File: rtl/psa_lane_add.sv
// One signed 4-bit lane adder with overflow detect and optional clamping.
module psa_lane_add
  import psa_pkg::*;
#(
  parameter int SATURATE = 1
) (
  input  nib_t a,
  input  nib_t b,
  output nib_t sum,
  output logic ovf
);

  nib_t w_wrap;

  // Modulo-16 sum; overflow is a sign flip when both operands share a sign.
  assign w_wrap = a + b;
  assign ovf    = (a[NIB_W-1] == b[NIB_W-1]) && (w_wrap[NIB_W-1] != a[NIB_W-1]);

  // Clamp toward the operands' sign only when saturation is enabled.
  always_comb begin
    sum = w_wrap;
    if ((SATURATE != 0) && ovf) begin
      sum = a[NIB_W-1] ? NIB_MIN : NIB_MAX;
    end
  end

endmodule

// File: rtl/psa_accum_unit.sv
// Streaming 4x4-bit signed sub-word accumulator with sticky lane overflow.
//
// state | meaning
// IDLE  | waiting for first beat, accumulator is zero
// ACCUM | stream in progress, folding beats into r_acc
// HOLD  | result presented, input stalled until consumer takes it
module psa_accum_unit
  import psa_pkg::*;
#(
  parameter int SATURATE  = 1,
  parameter int MAX_BEATS = 8,
  parameter int CNT_W     = $clog2(MAX_BEATS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_sum,
  output logic [3:0]       out_err,
  output logic             out_trunc,
  output logic [CNT_W-1:0] out_count
);

  psa_acc_state_t     r_state;
  psa_acc_state_t     w_state_nxt;
  psa_word_t          r_acc;
  psa_word_t          w_in;
  psa_word_t          w_sum;
  logic [NIBBLES-1:0] r_err;
  logic [NIBBLES-1:0] w_ovf;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               r_trunc;
  logic               w_beat;
  logic               w_deliver;
  logic               w_at_max;

  assign w_in      = in_data;
  assign w_beat    = in_valid && in_ready && !clear;
  assign w_deliver = out_valid && out_ready;
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_at_max  = (w_cnt_inc == CNT_W'(MAX_BEATS));

  for (genvar k = 0; k < NIBBLES; k++) begin : g_lane
    psa_lane_add #(
      .SATURATE(SATURATE)
    ) u_lane (
      .a  (r_acc[k]),
      .b  (w_in[k]),
      .sum(w_sum[k]),
      .ovf(w_ovf[k])
    );
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and handshake outputs; clear overrides every transition.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE, ACCUM: begin
        in_ready = 1'b1;
        if (w_beat) w_state_nxt = (in_last || w_at_max) ? HOLD : ACCUM;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (clear) w_state_nxt = IDLE;
  end

  // Accumulator, sticky flags, beat counter and truncation marker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_err   <= '0;
      r_cnt   <= '0;
      r_trunc <= 1'b0;
    end else if (clear || (w_deliver && !w_beat)) begin
      r_acc   <= '0;
      r_err   <= '0;
      r_cnt   <= '0;
      r_trunc <= 1'b0;
    end else if (w_beat) begin
      r_acc   <= w_sum;
      r_err   <= r_err | w_ovf;
      r_cnt   <= w_cnt_inc;
      r_trunc <= !in_last && w_at_max;
    end
  end

  // Result fields are only visible while a result is pending.
  assign out_sum   = out_valid ? r_acc   : '0;
  assign out_err   = out_valid ? r_err   : '0;
  assign out_count = out_valid ? r_cnt   : '0;
  assign out_trunc = out_valid ? r_trunc : 1'b0;

endmodule

// File: tb/tb_psa_accum_unit.sv
// Directed bench: saturating, wrapping and short-MAX_BEATS instances share stimulus.
module tb_psa_accum_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;

  logic        in_ready,  out_valid,  out_trunc;
  logic [15:0] out_sum;
  logic [3:0]  out_err;
  logic [3:0]  out_count;

  logic        in_ready_w, out_valid_w, out_trunc_w;
  logic [15:0] out_sum_w;
  logic [3:0]  out_err_w;
  logic [3:0]  out_count_w;

  logic        in_ready_t, out_valid_t, out_trunc_t;
  logic [15:0] out_sum_t;
  logic [3:0]  out_err_t;
  logic [2:0]  out_count_t;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    string       tag;
    logic [15:0] sum;
    logic [3:0]  err;
    logic [15:0] sum_w;
    logic [3:0]  err_w;
    logic [3:0]  cnt;
    logic        trunc;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  psa_accum_unit #(.SATURATE(1), .MAX_BEATS(8)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_err(out_err),
    .out_trunc(out_trunc), .out_count(out_count)
  );

  psa_accum_unit #(.SATURATE(0), .MAX_BEATS(8)) dut_w (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready_w), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid_w), .out_ready(out_ready), .out_sum(out_sum_w), .out_err(out_err_w),
    .out_trunc(out_trunc_w), .out_count(out_count_w)
  );

  psa_accum_unit #(.SATURATE(1), .MAX_BEATS(4)) dut_t (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready_t), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid_t), .out_ready(out_ready), .out_sum(out_sum_t), .out_err(out_err_t),
    .out_trunc(out_trunc_t), .out_count(out_count_t)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic push(input string tag, input logic [15:0] s, input logic [3:0] e,
                      input logic [15:0] sw, input logic [3:0] ew,
                      input logic [3:0] c, input logic t);
    exp_t x;
    x.tag = tag; x.sum = s; x.err = e; x.sum_w = sw; x.err_w = ew; x.cnt = c; x.trunc = t;
    sb.push_back(x);
  endtask

  // Present one beat at a negedge, hold until accepted, return at a negedge.
  task automatic send(input logic [15:0] d, input logic l);
    int t;
    t = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    while (in_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("send_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Wait for a result, compare against the oldest expectation, let it drain.
  task automatic get_result();
    int t;
    exp_t x;
    t = 0;
    while (out_valid !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("result_valid", 32'(out_valid), 32'd1);
    chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      x = sb.pop_front();
      chk({x.tag, "_sum"},   32'(out_sum),   32'(x.sum));
      chk({x.tag, "_err"},   32'(out_err),   32'(x.err));
      chk({x.tag, "_cnt"},   32'(out_count), 32'(x.cnt));
      chk({x.tag, "_trunc"}, 32'(out_trunc), 32'(x.trunc));
      chk({x.tag, "_sum_w"}, 32'(out_sum_w), 32'(x.sum_w));
      chk({x.tag, "_err_w"}, 32'(out_err_w), 32'(x.err_w));
    end
    chk("hold_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_sum_zero", 32'(out_sum), 32'd0);
    chk("bubble_ready", 32'(in_ready), 32'd1);
  endtask

  logic [15:0] held_sum;

  initial begin
    // Reset state.
    #12 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_sum", 32'(out_sum), 32'd0);
    chk("rst_err", 32'(out_err), 32'd0);
    chk("rst_cnt", 32'(out_count), 32'd0);
    chk("rst_trunc", 32'(out_trunc), 32'd0);

    // Basic add with one-cycle result latency.
    push("basic", 16'h2345, 4'b0000, 16'h2345, 4'b0000, 4'd2, 1'b0);
    send(16'h1234, 1'b0);
    chk("accum_no_valid", 32'(out_valid), 32'd0);
    chk("accum_sum_zero", 32'(out_sum), 32'd0);
    send(16'h1111, 1'b1);
    chk("latency", 32'(out_valid), 32'd1);
    get_result();

    // Positive overflow in lane 3.
    push("posovf", 16'h7000, 4'b1000, 16'h8000, 4'b1000, 4'd2, 1'b0);
    send(16'h7000, 1'b0);
    send(16'h1000, 1'b1);
    get_result();

    // Negative overflow in every lane, then sticky flags must be gone.
    push("negovf", 16'h8888, 4'b1111, 16'h7777, 4'b1111, 4'd2, 1'b0);
    send(16'h8888, 1'b0);
    send(16'hFFFF, 1'b1);
    get_result();
    push("after_ovf", 16'h0001, 4'b0000, 16'h0001, 4'b0000, 4'd1, 1'b0);
    send(16'h0001, 1'b1);
    get_result();

    // Backpressure: result held while a beat is offered.
    push("backpr", 16'h0033, 4'b0000, 16'h0033, 4'b0000, 4'd2, 1'b0);
    send(16'h0011, 1'b0);
    out_ready = 1'b0;
    send(16'h0022, 1'b1);
    held_sum = out_sum;
    in_valid = 1'b1; in_data = 16'h0100; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_ready", 32'(in_ready), 32'd0);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_stable", 32'(out_sum), 32'(held_sum));
    end
    in_valid = 1'b0; in_last = 1'b0;
    get_result();

    // Clear alongside a beat: the beat is discarded.
    send(16'h0101, 1'b0);
    in_valid = 1'b1; in_data = 16'h0505; clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; clear = 1'b0;
    chk("clr_valid", 32'(out_valid), 32'd0);
    chk("clr_ready", 32'(in_ready), 32'd1);
    push("after_clr", 16'h0202, 4'b0000, 16'h0202, 4'b0000, 4'd1, 1'b0);
    send(16'h0202, 1'b1);
    get_result();

    // Asynchronous reset while a result is pending: dropped at once.
    out_ready = 1'b0;
    send(16'h0303, 1'b0);
    send(16'h0404, 1'b1);
    chk("pre_rst_sum", 32'(out_sum), 32'h0707);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_sum", 32'(out_sum), 32'd0);
    chk("arst_cnt", 32'(out_count), 32'd0);
    chk("arst_err", 32'(out_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("arst_ready", 32'(in_ready), 32'd1);
    chk("arst_idle", 32'(out_valid), 32'd0);

    // Truncation on the short instance: four beats with no last.
    for (int i = 0; i < 4; i++) send(16'h1111, 1'b0);
    chk("tr_valid", 32'(out_valid_t), 32'd1);
    chk("tr_sum", 32'(out_sum_t), 32'h4444);
    chk("tr_cnt", 32'(out_count_t), 32'd4);
    chk("tr_trunc", 32'(out_trunc_t), 32'd1);
    chk("tr_ready", 32'(in_ready_t), 32'd0);
    chk("tr_main_busy", 32'(out_valid), 32'd0);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;

    // last on the MAX_BEATS-th beat wins over truncation.
    push("last_at_max", 16'h4444, 4'b0000, 16'h4444, 4'b0000, 4'd4, 1'b0);
    for (int i = 0; i < 3; i++) send(16'h1111, 1'b0);
    send(16'h1111, 1'b1);
    chk("tl_valid", 32'(out_valid_t), 32'd1);
    chk("tl_cnt", 32'(out_count_t), 32'd4);
    chk("tl_trunc", 32'(out_trunc_t), 32'd0);
    get_result();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
